// File: rtl/atm_db_arbiter.sv
// Round-robin arbiter sharing one single-port balance RAM between N_TERM ATM terminals.
// Each granted request runs a complete read-modify-write sequence before the next grant.
module atm_db_arbiter #(
    parameter int N_TERM = 4,
    parameter int ACC_W  = 4,
    parameter int BAL_W  = 14,
    parameter int N_ACC  = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_TERM-1:0]         req,
    input  logic [2*N_TERM-1:0]       op,
    input  logic [ACC_W*N_TERM-1:0]   acc,
    input  logic [BAL_W*N_TERM-1:0]   amt,
    output logic [N_TERM-1:0]         gnt,
    output logic                      done,
    output logic                      ok,
    output logic [BAL_W-1:0]          bal_out,
    output logic                      busy,
    output logic [ACC_W-1:0]          mem_addr,
    output logic                      mem_rd,
    input  logic [BAL_W-1:0]          mem_rdata,
    output logic                      mem_we,
    output logic [BAL_W-1:0]          mem_wdata
);

    localparam int PTR_W = (N_TERM > 1) ? $clog2(N_TERM) : 1;
    localparam logic [ACC_W:0] N_ACC_V = (ACC_W+1)'(N_ACC);

    typedef enum logic [2:0] {IDLE, RD, WAIT, EXEC, RESP} state_t;

    state_t state, state_nx;

    logic [PTR_W-1:0]  ptr, ptr_nx, win_c, win_q;
    logic              found, latch;
    int                idx;
    logic [1:0]        op_sel, op_q;
    logic [ACC_W-1:0]  acc_sel;
    logic [BAL_W-1:0]  amt_sel, amt_q, res_q;
    logic              okr_q;
    logic [BAL_W+1:0]  ex;

    logic [N_TERM-1:0] gnt_nx;
    logic              done_nx, ok_nx, busy_nx, mem_rd_nx, mem_we_nx;
    logic [BAL_W-1:0]  bal_nx, mem_wdata_nx;
    logic [ACC_W-1:0]  mem_addr_nx;

    // Returns {write, ok, resulting balance}; overdraft and overflow leave the balance untouched.
    function automatic logic [BAL_W+1:0] exec_op(input logic [1:0] o,
                                                 input logic [BAL_W-1:0] b,
                                                 input logic [BAL_W-1:0] a);
        logic [BAL_W:0] sum;
        sum = {1'b0, b} + {1'b0, a};
        exec_op = {1'b0, 1'b1, b};
        case (o)
            2'b01: begin
                if (a <= b) exec_op = {1'b1, 1'b1, b - a};
                else        exec_op = {1'b0, 1'b0, b};
            end
            2'b10: begin
                if (sum[BAL_W]) exec_op = {1'b0, 1'b0, b};
                else            exec_op = {1'b1, 1'b1, sum[BAL_W-1:0]};
            end
            default: ;
        endcase
    endfunction

    assign ex = exec_op(op_q, mem_rdata, amt_q);

    // Round-robin search starting at ptr.
    always_comb begin
        found = 1'b0;
        win_c = '0;
        idx   = 0;
        for (int k = 0; k < N_TERM; k++) begin
            idx = (int'(ptr) + k) % N_TERM;
            if (!found && req[idx]) begin
                found = 1'b1;
                win_c = PTR_W'(idx);
            end
        end
        op_sel  = op[2*win_c +: 2];
        acc_sel = acc[ACC_W*win_c +: ACC_W];
        amt_sel = amt[BAL_W*win_c +: BAL_W];
    end

    always_comb begin
        state_nx     = state;
        ptr_nx       = ptr;
        latch        = 1'b0;
        gnt_nx       = gnt;
        done_nx      = 1'b0;
        ok_nx        = 1'b0;
        bal_nx       = '0;
        mem_rd_nx    = 1'b0;
        mem_we_nx    = 1'b0;
        mem_addr_nx  = mem_addr;
        mem_wdata_nx = '0;
        case (state)
            IDLE: begin
                if (found) begin
                    latch  = 1'b1;
                    gnt_nx = N_TERM'(1) << win_c;
                    if (({1'b0, acc_sel} >= N_ACC_V) || (op_sel == 2'b11)) begin
                        state_nx = RESP;
                        done_nx  = 1'b1;
                    end else begin
                        state_nx    = RD;
                        mem_rd_nx   = 1'b1;
                        mem_addr_nx = acc_sel;
                    end
                end
            end
            RD: state_nx = WAIT;
            // Decide the write here so mem_we is registered high throughout EXEC.
            WAIT: begin
                state_nx     = EXEC;
                mem_we_nx    = ex[BAL_W+1];
                mem_wdata_nx = ex[BAL_W+1] ? ex[BAL_W-1:0] : '0;
            end
            EXEC: begin
                state_nx = RESP;
                done_nx  = 1'b1;
                ok_nx    = okr_q;
                bal_nx   = res_q;
            end
            RESP: begin
                state_nx = IDLE;
                gnt_nx   = '0;
                ptr_nx   = (win_q == PTR_W'(N_TERM-1)) ? '0 : win_q + 1'b1;
            end
            default: state_nx = IDLE;
        endcase
        busy_nx = (state_nx != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr       <= '0;
            gnt       <= '0;
            done      <= 1'b0;
            ok        <= 1'b0;
            bal_out   <= '0;
            busy      <= 1'b0;
            mem_rd    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            ptr       <= ptr_nx;
            gnt       <= gnt_nx;
            done      <= done_nx;
            ok        <= ok_nx;
            bal_out   <= bal_nx;
            busy      <= busy_nx;
            mem_rd    <= mem_rd_nx;
            mem_we    <= mem_we_nx;
            mem_addr  <= mem_addr_nx;
            mem_wdata <= mem_wdata_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (latch) begin
            win_q <= win_c;
            op_q  <= op_sel;
            amt_q <= amt_sel;
        end
        if (state == WAIT) begin
            okr_q <= ex[BAL_W];
            res_q <= ex[BAL_W-1:0];
        end
    end

endmodule
